lustre_unsigned_div_seq: RTL and testbench

Multi-cycle unsigned integer divider for the Lustre stdlib, computing quotient and remainder of two N-bit operands by restoring division, one quotient bit per clock. It sits directly downstream of the unsigned compare/subtract datapath. Each iteration consumes a trial subtraction whose carry-out is exactly the "partial remainder < divisor" decision. Generated code uses it wherever a Lustre `/` or `mod` on unsigned types is mapped to a sequential operator behind a start/done handshake.

---
 rtl/lustre_unsigned_div_seq_pkg.sv | 10 +
 rtl/internal_lustre_adder.sv | 21 ++
 rtl/lustre_unsigned_div_seq.sv | 116 +++++++++++
 tb/tb_lustre_unsigned_div_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lustre_unsigned_div_seq_pkg.sv
// rtl/lustre_unsigned_div_seq_pkg.sv - shared state encoding for the sequential unsigned divider
package lustre_unsigned_div_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/internal_lustre_adder.sv
// rtl/internal_lustre_adder.sv - W-bit adder with carry-in and carry-out flag
module internal_lustre_adder #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic [W-1:0] res,
    output logic         flag_C
);

    logic [W:0] sum;

    // One extra bit captures the carry-out; for a + ~b + 1 it means a >= b.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
        res    = sum[W-1:0];
        flag_C = sum[W];
    end

endmodule

// File: rtl/lustre_unsigned_div_seq.sv
// rtl/lustre_unsigned_div_seq.sv - restoring unsigned divider, one quotient bit per clock
module lustre_unsigned_div_seq
    import lustre_unsigned_div_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] num,
    input  logic [N-1:0] den,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = N + 1;

    state_t        state;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic [N-1:0]  qsr;
    logic [N:0]    p;
    logic [CW-1:0] cnt;

    logic [N:0]    p_shift;
    logic [N:0]    p_sub;
    logic [N:0]    p_next;
    logic [N-1:0]  qsr_next;
    logic          not_less;
    logic          accept;

    // Shift the next dividend bit into the partial remainder; the old top bit of P
    // is always zero after an iteration, so the cast just drops it.
    always_comb begin
        p_shift  = PW'({p, dividend[N-1]});
        p_next   = not_less ? p_sub : p_shift;
        qsr_next = N'({qsr, not_less});
        accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    end

    // Trial subtraction P' - den; carry-out set means P' >= den.
    internal_lustre_adder #(
        .W(N + 1)
    ) u_trial (
        .a        (p_shift),
        .b        (~{1'b0, divisor}),
        .carry_in (1'b1),
        .res      (p_sub),
        .flag_C   (not_less)
    );

    // Control FSM with datapath registers; results only move on entry to DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dividend    <= '0;
            divisor     <= '0;
            qsr         <= '0;
            p           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (den == '0) begin
                    state       <= ST_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quot        <= '1;
                    rem         <= num;
                    div_by_zero <= 1'b1;
                end else begin
                    state    <= ST_RUN;
                    busy     <= 1'b1;
                    dividend <= num;
                    divisor  <= den;
                    qsr      <= '0;
                    p        <= '0;
                    cnt      <= CW'(N);
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        p        <= p_next;
                        qsr      <= qsr_next;
                        dividend <= dividend << 1;
                        cnt      <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quot        <= qsr_next;
                            rem         <= p_next[N-1:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lustre_unsigned_div_seq.sv
// tb/tb_lustre_unsigned_div_seq.sv - directed and table-driven bench for the sequential divider
module tb_lustre_unsigned_div_seq;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [12:0] num;
    logic [12:0] den;

    logic        busy1, done1, dbz1;
    logic [0:0]  quot1, rem1;
    logic        busy8, done8, dbz8;
    logic [7:0]  quot8, rem8;
    logic        busy13, done13, dbz13;
    logic [12:0] quot13, rem13;

    logic        busy_v [3];
    logic        done_v [3];
    logic        dbz_v  [3];
    logic [12:0] quot_v [3];
    logic [12:0] rem_v  [3];

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [12:0] a;
        logic [12:0] b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        z;
        string       nm;
    } vec_t;

    vec_t vecs [10];

    lustre_unsigned_div_seq #(.N(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .num(num[0:0]), .den(den[0:0]),
        .busy(busy1), .done(done1), .quot(quot1), .rem(rem1), .div_by_zero(dbz1)
    );

    lustre_unsigned_div_seq #(.N(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start), .num(num[7:0]), .den(den[7:0]),
        .busy(busy8), .done(done8), .quot(quot8), .rem(rem8), .div_by_zero(dbz8)
    );

    lustre_unsigned_div_seq #(.N(13)) dut13 (
        .clock(clock), .reset_n(reset_n), .start(start), .num(num), .den(den),
        .busy(busy13), .done(done13), .quot(quot13), .rem(rem13), .div_by_zero(dbz13)
    );

    always_comb begin
        busy_v[0] = busy1;  done_v[0] = done1;  dbz_v[0] = dbz1;
        quot_v[0] = {12'b0, quot1};  rem_v[0] = {12'b0, rem1};
        busy_v[1] = busy8;  done_v[1] = done8;  dbz_v[1] = dbz8;
        quot_v[1] = {5'b0, quot8};   rem_v[1] = {5'b0, rem8};
        busy_v[2] = busy13; done_v[2] = done13; dbz_v[2] = dbz13;
        quot_v[2] = quot13;          rem_v[2] = rem13;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts one division on all three widths and checks latency, busy length and results.
    task automatic run_div(input logic [12:0] a, input logic [12:0] b,
                           input logic [7:0] q8, input logic [7:0] r8, input logic z8,
                           input string nm);
        int          w [3];
        int          lat [3];
        int          bcnt [3];
        bit          got [3];
        int          eq, er, ez, elat, mask, na, nb;
        int          overlap;
        w[0] = 1; w[1] = 8; w[2] = 13;
        overlap = 0;
        for (int k = 0; k < 3; k++) begin
            lat[k] = -1; bcnt[k] = 0; got[k] = 1'b0;
        end
        start = 1'b1; num = a; den = b;
        tick();
        start = 1'b0;
        for (int j = 0; j < 30; j++) begin
            for (int k = 0; k < 3; k++) begin
                if (busy_v[k] && done_v[k]) overlap++;
                if (!got[k]) begin
                    if (done_v[k]) begin
                        got[k] = 1'b1;
                        lat[k] = j;
                    end else if (busy_v[k]) begin
                        bcnt[k]++;
                    end
                end
            end
            if (got[0] && got[1] && got[2]) break;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            mask = (1 << w[k]) - 1;
            na = int'(a) & mask;
            nb = int'(b) & mask;
            if (k == 1) begin
                eq = q8; er = r8; ez = z8;
            end else if (nb == 0) begin
                eq = mask; er = na; ez = 1;
            end else begin
                eq = na / nb; er = na % nb; ez = 0;
            end
            elat = (nb == 0) ? 0 : w[k];
            check($sformatf("%s_n%0d_latency", nm, w[k]), lat[k], elat);
            check($sformatf("%s_n%0d_busy_cycles", nm, w[k]), bcnt[k], elat);
            if (got[k]) begin
                check($sformatf("%s_n%0d_quot", nm, w[k]), int'(quot_v[k]), eq);
                check($sformatf("%s_n%0d_rem", nm, w[k]), int'(rem_v[k]), er);
                check($sformatf("%s_n%0d_dbz", nm, w[k]), int'(dbz_v[k]), ez);
            end
        end
        check($sformatf("%s_busy_done_overlap", nm), overlap, 0);
        tick();
    endtask

    initial begin
        int j;
        int stable_bad;
        int done_seen;
        logic [12:0] ra, rb;

        vecs[0] = '{13'd100, 13'd7,   8'd14,  8'd2,   1'b0, "v100_7"};
        vecs[1] = '{13'd255, 13'd128, 8'd1,   8'd127, 1'b0, "v255_128"};
        vecs[2] = '{13'd5,   13'd200, 8'd0,   8'd5,   1'b0, "v5_200"};
        vecs[3] = '{13'd255, 13'd1,   8'd255, 8'd0,   1'b0, "v255_1"};
        vecs[4] = '{13'd200, 13'd0,   8'd255, 8'd200, 1'b1, "v200_0"};
        vecs[5] = '{13'd9,   13'd3,   8'd3,   8'd0,   1'b0, "v9_3"};
        vecs[6] = '{13'd0,   13'd5,   8'd0,   8'd0,   1'b0, "v0_5"};
        vecs[7] = '{13'd0,   13'd0,   8'd255, 8'd0,   1'b1, "v0_0"};
        vecs[8] = '{13'd7,   13'd7,   8'd1,   8'd0,   1'b0, "v7_7"};
        vecs[9] = '{13'd254, 13'd255, 8'd0,   8'd254, 1'b0, "v254_255"};

        reset_n = 1'b0; start = 1'b0; num = '0; den = '0;
        #2;
        check("reset_busy", int'(busy8), 0);
        check("reset_done", int'(done8), 0);
        check("reset_quot", int'(quot8), 0);
        check("reset_rem", int'(rem8), 0);
        check("reset_dbz", int'(dbz8), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].nm);

        // start held with changing operands during RUN, then accepted again in DONE
        start = 1'b1; num = 13'd100; den = 13'd7;
        tick();
        num = 13'd200; den = 13'd9;
        j = 0;
        while (!done8 && j < 30) begin
            tick();
            j++;
        end
        check("held_first_latency", j, 8);
        check("held_first_quot", int'(quot8), 14);
        check("held_first_rem", int'(rem8), 2);
        tick();
        start = 1'b0;
        j = 1;
        stable_bad = 0;
        while (!done8 && j < 30) begin
            if (quot8 !== 8'd14 || rem8 !== 8'd2) stable_bad++;
            tick();
            j++;
        end
        check("b2b_done_gap", j, 9);
        check("b2b_quot_stable_in_run", stable_bad, 0);
        check("b2b_quot", int'(quot8), 22);
        check("b2b_rem", int'(rem8), 2);
        repeat (16) tick();

        // back-to-back divide-by-zero gives done on consecutive cycles
        start = 1'b1; num = 13'd200; den = 13'd0;
        tick();
        check("dz_b2b_done1", int'(done8), 1);
        check("dz_b2b_rem1", int'(rem8), 200);
        num = 13'd7;
        tick();
        check("dz_b2b_done2", int'(done8), 1);
        check("dz_b2b_rem2", int'(rem8), 7);
        check("dz_b2b_dbz", int'(dbz8), 1);
        start = 1'b0;
        tick();
        check("dz_b2b_done_drop", int'(done8), 0);
        repeat (16) tick();

        // reset in the middle of 100/7 aborts without a done pulse
        run_div(13'd100, 13'd7, 8'd14, 8'd2, 1'b0, "pre_abort");
        start = 1'b1; num = 13'd100; den = 13'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_busy_before", int'(busy8), 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", int'(busy8), 0);
        check("abort_done", int'(done8), 0);
        check("abort_quot", int'(quot8), 0);
        check("abort_rem", int'(rem8), 0);
        check("abort_dbz", int'(dbz8), 0);
        tick();
        reset_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8 || busy8) done_seen++;
            tick();
        end
        check("abort_no_done", done_seen, 0);
        run_div(13'd50, 13'd6, 8'd8, 8'd2, 1'b0, "after_abort");

        // random sweep, expected values from the reference operators
        for (int i = 0; i < 20; i++) begin
            ra = 13'($urandom_range(0, 8191));
            rb = 13'($urandom_range(0, 8191));
            if (i % 4 == 0) rb = 13'($urandom_range(0, 3));
            if (rb[7:0] == 8'd0)
                run_div(ra, rb, 8'd255, ra[7:0], 1'b1, $sformatf("rnd%0d", i));
            else
                run_div(ra, rb, ra[7:0] / rb[7:0], ra[7:0] % rb[7:0], 1'b0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
